sram_mem_controller: RTL and testbench

//  Sequences the MEM stage's data accesses onto an external 16-bit asynchronous SRAM.
//  - Each 32-bit word is transferred as two 16-bit halves.
//  - Drives 'ready' low while an access is in flight; the top level uses ~ready as the

---
 rtl/sram_mem_controller_pkg.sv | 17 +
 rtl/sram_mem_controller_if.sv | 33 +++
 rtl/sram_mem_controller_phase_counter.sv | 27 ++
 rtl/sram_mem_controller.sv | 125 ++++++++++++
 tb/tb_sram_mem_controller.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller: FSM state
// encoding, default base address and bus widths.
package sram_mem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int          SRAM_AW_DEF   = 18;
  localparam int          SRAM_DW       = 16;
  localparam int          CPU_DW        = 32;

endpackage

// File: rtl/sram_mem_controller_if.sv
// Bundles the CPU-side MEM request and the SRAM pad signals of the controller.
interface sram_mem_controller_if #(
  parameter int AW = sram_mem_controller_pkg::SRAM_AW_DEF
) ();
  import sram_mem_controller_pkg::*;

  // Handshake: the requester raises rd_en or wr_en and holds it until ready=1;
  // ready stays 0 while an access is in flight and returns to 1 in the final
  // cycle of that access, after which the next request may be presented.
  logic              rd_en;
  logic              wr_en;
  logic [CPU_DW-1:0] address;
  logic [CPU_DW-1:0] write_data;
  logic [CPU_DW-1:0] read_data;
  logic              ready;

  logic [AW-1:0]      sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

endinterface

// File: rtl/sram_mem_controller_phase_counter.sv
// Cycle counter for one 16-bit SRAM phase; flags the last cycle of the phase.
module sram_mem_controller_phase_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tc_o
);

  localparam int            CW   = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_d = clr_i ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller that moves one 32-bit word per access to a 16-bit
// asynchronous SRAM as a low half then a high half, stalling the pipeline.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          WAIT_CYCLES = 3,
  parameter int          SRAM_AW     = SRAM_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_mem_controller_if.slave  bus,
  output state_t                state_o
);

  state_t              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [SRAM_AW-2:0]  hw_q, hw_d;
  logic [CPU_DW-1:0]   wdata_q, wdata_d;
  logic [CPU_DW-1:0]   rdata_q, rdata_d;

  logic                req;
  logic                cnt_clr;
  logic                cnt_tc;
  logic                in_phase;
  logic [CPU_DW-1:0]   off;
  logic                unused_off_bits;

  assign req = bus.rd_en | bus.wr_en;

  // Word index inside the SRAM window; byte-lane bits and bits above the
  // SRAM's reach are dropped, so addresses alias modulo the SRAM size.
  assign off             = bus.address - BASE_ADDR;
  assign unused_off_bits = ^{off[CPU_DW-1:SRAM_AW+1], off[1:0]};

  sram_mem_controller_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      hw_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      hw_q    <= hw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    hw_d    = hw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_clr = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_LO;
          is_wr_d = bus.wr_en;
          hw_d    = off[SRAM_AW:2];
          wdata_d = bus.write_data;
        end
      end
      ST_LO: begin
        // Clearing on the terminal count restarts the counter for the HI phase.
        cnt_clr = cnt_tc;
        if (cnt_tc) begin
          state_d = ST_HI;
          if (!is_wr_q) rdata_d[SRAM_DW-1:0] = bus.sram_dq_in;
        end
      end
      ST_HI: begin
        cnt_clr = cnt_tc;
        if (cnt_tc) begin
          state_d = ST_DONE;
          if (!is_wr_q) rdata_d[CPU_DW-1:SRAM_DW] = bus.sram_dq_in;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_phase = (state_q == ST_LO) || (state_q == ST_HI);

  // The strobe rises in the last cycle of each phase so address and data are
  // held stable across the SRAM's write-end edge.
  always_comb begin
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    if (in_phase) begin
      bus.sram_addr = {hw_q, (state_q == ST_HI)};
      if (is_wr_q) begin
        bus.sram_dq_oe  = 1'b1;
        bus.sram_dq_out = (state_q == ST_HI) ? wdata_q[CPU_DW-1:SRAM_DW]
                                             : wdata_q[SRAM_DW-1:0];
        bus.sram_we_n   = cnt_tc;
      end
    end
  end

  assign bus.ready     = ~req | (state_q == ST_DONE);
  assign bus.read_data = rdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: fixed vector table, reset-abort sequence and
// random word accesses checked against a word-level memory model.
module tb_sram_mem_controller;
  import sram_mem_controller_pkg::*;

  localparam int WC = 3;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  sram_mem_controller_if #(.AW(18)) bus ();

  sram_mem_controller #(
    .BASE_ADDR   (1024),
    .WAIT_CYCLES (WC),
    .SRAM_AW     (18)
  ) dut (
    .clk     (clk),
    .rst     (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- SRAM pad model (environment) ----------------
  logic [15:0] sram_arr [int];

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (sram_arr.exists(int'(a))) return sram_arr[int'(a)];
    return 16'h0000;
  endfunction

  initial begin
    bus.sram_dq_in = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.sram_we_n === 1'b0 && bus.sram_dq_oe === 1'b1)
        sram_arr[int'(bus.sram_addr)] = bus.sram_dq_out;
      bus.sram_dq_in = sram_rd(bus.sram_addr);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd;
  logic [31:0] exp_q [$];
  int total;
  int bad;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return int'((o >> 2) & 32'h0001_FFFF);
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    check("idle_ready", bus.ready, 1);
    check("idle_we_n", bus.sram_we_n, 1);
    check("idle_oe", bus.sram_dq_oe, 0);
    check("idle_addr", bus.sram_addr, 0);
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic [17:0] exp_lo, input bit scramble);
    int c, we_cnt, oe_cnt;
    logic [17:0] a_lo, a_hi;
    logic [15:0] d_lo, d_hi;
    bit done;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    bus.rd_en = rd;
    bus.wr_en = wr;
    bus.address = addr;
    bus.write_data = wdata;
    #1;
    check("ready_c0", bus.ready, 0);
    c = 0; done = 0; we_cnt = 0; oe_cnt = 0;
    a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
      if (scramble) begin
        bus.address = $urandom;
        bus.write_data = $urandom;
      end
      #1;
      if (bus.sram_we_n === 1'b0) we_cnt++;
      if (bus.sram_dq_oe === 1'b1) oe_cnt++;
      if (c == 1) d_lo = bus.sram_dq_out;
      if (c == WC) a_lo = bus.sram_addr;
      if (c == WC + 1) d_hi = bus.sram_dq_out;
      if (c == 2 * WC) a_hi = bus.sram_addr;
      if (bus.ready === 1'b1) done = 1;
    end
    check("stall_len", c, 2 * WC + 1);
    check("read_data", bus.read_data, exp_q.pop_front());
    check("we_low_cycles", we_cnt, wr ? 2 * (WC - 1) : 0);
    check("oe_cycles", oe_cnt, wr ? 2 * WC : 0);
    check("addr_lo", a_lo, exp_lo);
    check("addr_hi", a_hi, exp_lo | 18'd1);
    if (wr) begin
      check("dq_lo", d_lo, wdata[15:0]);
      check("dq_hi", d_hi, wdata[31:16]);
      check("sram_lo", sram_rd(exp_lo), wdata[15:0]);
      check("sram_hi", sram_rd(exp_lo | 18'd1), wdata[31:16]);
      ref_mem[widx(addr)] = wdata;
    end else begin
      ref_rd = ref_word(widx(addr));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic        r_rd, r_wr;
    logic [31:0] r_addr, r_wd, r_exp;
    int          w;

    vecs[0] = '{1'b0, 1'b1, 32'd1024,    32'hDEADBEEF, 32'h00000000, 18'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024,    32'h00000000, 32'hDEADBEEF, 18'd0};
    vecs[2] = '{1'b0, 1'b1, 32'd1032,    32'h12345678, 32'hDEADBEEF, 18'd4};
    vecs[3] = '{1'b1, 1'b0, 32'd1032,    32'h00000000, 32'h12345678, 18'd4};
    vecs[4] = '{1'b1, 1'b1, 32'd1028,    32'hCAFEF00D, 32'h12345678, 18'd2};
    vecs[5] = '{1'b1, 1'b0, 32'd1028,    32'h00000000, 32'hCAFEF00D, 18'd2};
    vecs[6] = '{1'b0, 1'b1, 32'h00080403, 32'h0BADC0DE, 32'hCAFEF00D, 18'd0};
    vecs[7] = '{1'b1, 1'b0, 32'd1027,    32'h00000000, 32'h0BADC0DE, 18'd0};
    vecs[8] = '{1'b0, 1'b1, 32'd1020,    32'h55AA33CC, 32'h0BADC0DE, 18'h3FFFE};
    vecs[9] = '{1'b1, 1'b0, 32'd1020,    32'h00000000, 32'h55AA33CC, 18'h3FFFE};

    total = 0;
    bad = 0;
    ref_rd = 32'h0;
    rst_n = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.address = 32'h0;
    bus.write_data = 32'h0;

    // Reset held, then released with no request.
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_read_data", bus.read_data, 0);
    check("rst_we_n", bus.sram_we_n, 1);
    check("rst_oe", bus.sram_dq_oe, 0);
    check("rst_addr", bus.sram_addr, 0);
    check("rst_ready", bus.ready, 1);
    rst_n = 1'b1;
    idle_cycle();
    idle_cycle();

    // Table vectors, applied back-to-back.
    for (int i = 0; i < 10; i++)
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_lo, 1'b0);
    idle_cycle();

    // Reset asserted during the HI phase of a write.
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.address = 32'd1824;
    bus.write_data = 32'hA5A5_5A5A;
    repeat (WC + 2) @(negedge clk);
    #1;
    check("abort_pre_state", 32'(dbg_state), 32'(ST_HI));
    check("abort_pre_we_n", bus.sram_we_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_we_n", bus.sram_we_n, 1);
    check("abort_oe", bus.sram_dq_oe, 0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_read_data", bus.read_data, 0);
    check("abort_ready_req", bus.ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_ready_req", bus.ready, 0);
    bus.wr_en = 1'b0;
    #1;
    check("release_ready_noreq", bus.ready, 1);
    ref_rd = 32'h0;
    idle_cycle();
    check("release_state", 32'(dbg_state), 32'(ST_IDLE));

    // Random accesses against the word-level model; some with inputs
    // scrambled after acceptance.
    for (int i = 0; i < 40; i++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_wr = 1'($urandom_range(0, 1));
      if (!r_rd && !r_wr) r_rd = 1'b1;
      r_addr = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      r_wd = $urandom;
      w = widx(r_addr);
      r_exp = r_wr ? ref_rd : ref_word(w);
      do_access(r_rd, r_wr, r_addr, r_wd, r_exp, 18'(w * 2), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
